// File: rtl/reorder_commit_buffer.sv
// In-order retirement buffer: allocates tags, collects out-of-order results, retires at head.
// Commit is registered one edge after the head entry becomes ready; the dispatcher stalls on issue_ready=0; rdy_in=0 pauses everything.
module reorder_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_addr,
  output logic             issue_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_val,
  input  logic             wb_mispredict,
  input  logic [TAG_W-1:0] qry_tag,
  output logic             qry_ready,
  output logic [31:0]      qry_val,
  output logic             commit_active,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_val,
  output logic [31:0]      commit_addr,
  output logic [4:0]       commit_rd_idx,
  output logic             predict_fail
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_mis;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_val  [DEPTH];
  logic [31:0]      r_addr [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic          w_full;
  logic          w_issue;
  logic          w_commit;
  logic          w_flush;
  logic          w_wb_inrange;
  logic [PW-1:0] w_wb_idx;
  logic          w_wb_hit;
  logic          w_q_inrange;
  logic [PW-1:0] w_q_idx;

  assign w_full      = (r_count == CW'(DEPTH));
  assign issue_ready = ~w_full;
  assign alloc_tag   = TAG_W'(r_tail) + TAG_W'(1);
  assign w_issue     = issue_valid & ~w_full;
  assign w_commit    = r_busy[r_head] & r_ready[r_head];
  assign w_flush     = w_commit & r_mis[r_head];

  // Tag 0 and tags beyond DEPTH never map to an entry; such writebacks are stale.
  assign w_wb_inrange = (wb_tag != '0) && (wb_tag <= TAG_W'(DEPTH));
  assign w_wb_idx     = PW'(wb_tag - TAG_W'(1));
  assign w_wb_hit     = wb_valid & w_wb_inrange & r_busy[w_wb_idx];

  assign w_q_inrange = (qry_tag != '0) && (qry_tag <= TAG_W'(DEPTH));
  assign w_q_idx     = PW'(qry_tag - TAG_W'(1));
  assign qry_ready   = w_q_inrange & r_busy[w_q_idx] & r_ready[w_q_idx];
  assign qry_val     = qry_ready ? r_val[w_q_idx] : 32'h0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy        <= '0;
      r_ready       <= '0;
      r_mis         <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      commit_active <= 1'b0;
      commit_tag    <= '0;
      commit_val    <= '0;
      commit_addr   <= '0;
      commit_rd_idx <= '0;
      predict_fail  <= 1'b0;
    end else if (rdy_in) begin
      commit_active <= w_commit;
      predict_fail  <= w_flush;
      if (w_commit) begin
        commit_tag    <= TAG_W'(r_head) + TAG_W'(1);
        commit_val    <= r_val[r_head];
        commit_addr   <= r_addr[r_head];
        commit_rd_idx <= r_rd[r_head];
      end
      if (w_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_mis   <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_mis[r_tail]   <= 1'b0;
          r_tail          <= r_tail + PW'(1);
        end
        if (w_wb_hit) begin
          r_ready[w_wb_idx] <= 1'b1;
          r_mis[w_wb_idx]   <= wb_mispredict;
        end
        // Retirement clears last so it wins over a writeback to the same slot.
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_mis[r_head]   <= 1'b0;
          r_head          <= r_head + PW'(1);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end else begin
      commit_active <= 1'b0;
      predict_fail  <= 1'b0;
    end
  end

  // Payload storage is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_issue) begin
        r_rd[r_tail]   <= issue_rd;
        r_addr[r_tail] <= issue_addr;
      end
      if (w_wb_hit) begin
        r_val[w_wb_idx] <= wb_val;
      end
    end
  end

endmodule

// File: tb/tb_reorder_commit_buffer.sv
// Directed bench for reorder_commit_buffer: a vector table for in-order retirement plus hand sequences for corner cases.
module tb_reorder_commit_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] issue_addr;
  logic        issue_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic        wb_mispredict;
  logic [3:0]  qry_tag;
  logic        qry_ready;
  logic [31:0] qry_val;
  logic        commit_active;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;
  logic [31:0] commit_addr;
  logic [4:0]  commit_rd_idx;
  logic        predict_fail;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  reorder_commit_buffer #(.DEPTH(8), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_mispredict(wb_mispredict),
    .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_val(qry_val),
    .commit_active(commit_active), .commit_tag(commit_tag), .commit_val(commit_val),
    .commit_addr(commit_addr), .commit_rd_idx(commit_rd_idx), .predict_fail(predict_fail)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic        wv;
    logic [3:0]  wtag;
    logic [31:0] wval;
    logic        e_act;
    logic [3:0]  e_tag;
    logic [31:0] e_val;
    logic [4:0]  e_rd;
    logic [31:0] e_addr;
    logic        e_ir;
    logic [3:0]  e_at;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [4:0] rd, input logic [31:0] addr,
                         input logic wv, input logic [3:0] wtag, input logic [31:0] wval,
                         input logic e_act, input logic [3:0] e_tag, input logic [31:0] e_val,
                         input logic [4:0] e_rd, input logic [31:0] e_addr,
                         input logic e_ir, input logic [3:0] e_at);
    vec_t v;
    v.iv = iv; v.rd = rd; v.addr = addr; v.wv = wv; v.wtag = wtag; v.wval = wval;
    v.e_act = e_act; v.e_tag = e_tag; v.e_val = e_val; v.e_rd = e_rd; v.e_addr = e_addr;
    v.e_ir = e_ir; v.e_at = e_at;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; issue_addr = 0;
    wb_valid = 0; wb_tag = 0; wb_val = 0; wb_mispredict = 0;
    qry_tag = 0; rdy_in = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 0;
    tick();
    tick();
    rst_n_in = 1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] addr);
    issue_valid = 1; issue_rd = rd; issue_addr = addr;
    tick();
    issue_valid = 0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic mis);
    wb_valid = 1; wb_tag = tag; wb_val = val; wb_mispredict = mis;
    tick();
    wb_valid = 0; wb_mispredict = 0;
  endtask

  initial begin
    rst_n_in = 0;
    idle_inputs();

    // In-order retirement of out-of-order results
    add_vec(1, 5'd1, 32'h100, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd2);
    add_vec(1, 5'd2, 32'h104, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd3);
    add_vec(1, 5'd3, 32'h108, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   1, 4'd3, 32'h30, 0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   1, 4'd1, 32'h10, 0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   1, 4'd2, 32'h20, 1, 4'd1, 32'h10, 5'd1, 32'h100, 1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   0, 4'd0, 32'h0,  1, 4'd2, 32'h20, 5'd2, 32'h104, 1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   0, 4'd0, 32'h0,  1, 4'd3, 32'h30, 5'd3, 32'h108, 1, 4'd4);
    add_vec(0, 5'd0, 32'h0,   0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  5'd0, 32'h0,   1, 4'd4);

    do_reset();
    chk("rst_commit_active", 32'(commit_active), 0);
    chk("rst_predict_fail", 32'(predict_fail), 0);
    chk("rst_commit_tag", 32'(commit_tag), 0);
    chk("rst_commit_val", commit_val, 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_alloc_tag", 32'(alloc_tag), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      issue_valid = vecs[i].iv; issue_rd = vecs[i].rd; issue_addr = vecs[i].addr;
      wb_valid = vecs[i].wv; wb_tag = vecs[i].wtag; wb_val = vecs[i].wval; wb_mispredict = 0;
      tick();
      chk($sformatf("v%0d_commit_active", i), 32'(commit_active), 32'(vecs[i].e_act));
      chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].e_at));
      chk($sformatf("v%0d_predict_fail", i), 32'(predict_fail), 0);
      if (vecs[i].e_act) begin
        chk($sformatf("v%0d_commit_tag", i), 32'(commit_tag), 32'(vecs[i].e_tag));
        chk($sformatf("v%0d_commit_val", i), commit_val, vecs[i].e_val);
        chk($sformatf("v%0d_commit_rd", i), 32'(commit_rd_idx), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_commit_addr", i), commit_addr, vecs[i].e_addr);
      end
    end
    idle_inputs();

    // Fill to full, refuse extra issue, wrap the tag
    do_reset();
    for (int i = 0; i < 8; i++) issue(5'(i + 1), 32'h200 + 32'(i * 4));
    chk("full_issue_ready", 32'(issue_ready), 0);
    chk("full_alloc_tag", 32'(alloc_tag), 1);
    issue(5'd20, 32'hdead);
    chk("full_refuse_ready", 32'(issue_ready), 0);
    chk("full_refuse_alloc", 32'(alloc_tag), 1);
    wb(4'd1, 32'h11, 0);
    chk("full_wb_no_commit", 32'(commit_active), 0);
    chk("full_wb_still_full", 32'(issue_ready), 0);
    issue(5'd21, 32'hbeef);  // full and commit on the same edge: refused
    chk("full_commit_active", 32'(commit_active), 1);
    chk("full_commit_tag", 32'(commit_tag), 1);
    chk("full_commit_rd", 32'(commit_rd_idx), 1);
    chk("full_after_commit_ready", 32'(issue_ready), 1);
    chk("full_after_commit_alloc", 32'(alloc_tag), 1);
    issue(5'd9, 32'h300);
    chk("wrap_issue_full", 32'(issue_ready), 0);
    chk("wrap_alloc_tag", 32'(alloc_tag), 2);
    wb(4'd1, 32'h99, 0);
    qry_tag = 4'd1; #1;
    chk("wrap_qry_ready", 32'(qry_ready), 1);
    chk("wrap_qry_val", qry_val, 32'h99);
    idle_inputs();

    // Mispredict flush
    do_reset();
    issue(5'd1, 32'h400); issue(5'd2, 32'h404); issue(5'd3, 32'h408);
    wb(4'd2, 32'h22, 1);
    wb(4'd1, 32'h11, 0);
    chk("mp_no_commit_yet", 32'(commit_active), 0);
    tick();
    chk("mp_commit1_active", 32'(commit_active), 1);
    chk("mp_commit1_tag", 32'(commit_tag), 1);
    chk("mp_commit1_pf", 32'(predict_fail), 0);
    issue(5'd7, 32'h500);  // discarded by the flush
    chk("mp_commit2_active", 32'(commit_active), 1);
    chk("mp_commit2_tag", 32'(commit_tag), 2);
    chk("mp_commit2_val", commit_val, 32'h22);
    chk("mp_commit2_addr", commit_addr, 32'h404);
    chk("mp_pf", 32'(predict_fail), 1);
    chk("mp_alloc_tag", 32'(alloc_tag), 1);
    chk("mp_issue_ready", 32'(issue_ready), 1);
    wb(4'd3, 32'h33, 0);
    chk("mp_pf_drop", 32'(predict_fail), 0);
    chk("mp_idle_after", 32'(commit_active), 0);
    tick();
    chk("mp_stale_no_commit", 32'(commit_active), 0);
    qry_tag = 4'd3; #1;
    chk("mp_stale_qry", 32'(qry_ready), 0);
    chk("mp_alloc_final", 32'(alloc_tag), 1);
    idle_inputs();

    // Pause with rdy_in low
    do_reset();
    issue(5'd4, 32'h600);
    rdy_in = 0; wb_valid = 1; wb_tag = 4'd1; wb_val = 32'h44;
    tick();
    chk("pause_no_commit_a", 32'(commit_active), 0);
    tick();
    chk("pause_no_commit_b", 32'(commit_active), 0);
    rdy_in = 1;
    tick();
    wb_valid = 0;
    chk("pause_resume_wb", 32'(commit_active), 0);
    tick();
    chk("pause_commit_active", 32'(commit_active), 1);
    chk("pause_commit_val", commit_val, 32'h44);
    issue(5'd5, 32'h604);
    wb(4'd2, 32'h45, 0);
    rdy_in = 0;
    tick();
    chk("pause_ready_head_held", 32'(commit_active), 0);
    chk("pause_tag_holds", 32'(commit_tag), 1);
    rdy_in = 1;
    tick();
    chk("pause_commit2_active", 32'(commit_active), 1);
    chk("pause_commit2_tag", 32'(commit_tag), 2);
    idle_inputs();

    // Operand query, no same-cycle forwarding
    do_reset();
    issue(5'd6, 32'h700);
    wb_valid = 1; wb_tag = 4'd1; wb_val = 32'h55; qry_tag = 4'd1; #1;
    chk("qry_no_forward", 32'(qry_ready), 0);
    chk("qry_no_forward_val", qry_val, 0);
    tick();
    wb_valid = 0; #1;
    chk("qry_ready", 32'(qry_ready), 1);
    chk("qry_val", qry_val, 32'h55);
    qry_tag = 4'd0; #1;
    chk("qry_tag0_ready", 32'(qry_ready), 0);
    chk("qry_tag0_val", qry_val, 0);
    idle_inputs();

    // Asynchronous reset between edges with entries pending
    do_reset();
    issue(5'd1, 32'h800); issue(5'd2, 32'h804);
    wb(4'd1, 32'h81, 0);
    wb(4'd2, 32'h82, 0);
    chk("arst_pre_active", 32'(commit_active), 1);
    #2 rst_n_in = 0;
    #1;
    chk("arst_commit_active", 32'(commit_active), 0);
    chk("arst_commit_tag", 32'(commit_tag), 0);
    chk("arst_issue_ready", 32'(issue_ready), 1);
    chk("arst_alloc_tag", 32'(alloc_tag), 1);
    #1 rst_n_in = 1;
    tick();
    chk("arst_no_pending", 32'(commit_active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
